// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared defaults, types and helpers for the write-back arbiter
package wb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int CW_DEF   = 16;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_req_t;

  typedef logic [$clog2(NREQ_DEF)-1:0] req_idx_t;

  // Ring increment for requester indices whose count need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester handshake bus plus the two regfile write ports
interface wb_port_arbiter_if
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][DW-1:0]  req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     we_1;
  logic [AW-1:0]            writeaddr_1;
  logic [DW-1:0]            writedata_1;
  logic                     we_2;
  logic [AW-1:0]            writeaddr_2;
  logic [DW-1:0]            writedata_2;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2
  );
endinterface

// File: rtl/wb_port_arbiter_rr_pick.sv
// rtl/wb_port_arbiter_rr_pick.sv - first unmasked valid bit at or after start, wrapping
module wb_port_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0] cand;
  int           pos;

  assign cand = valid & ~mask;

  // Walk the ring backwards so the nearest candidate to start is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (cand[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter mapping up to two completing writes onto the regfile ports
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  wb_port_arbiter_if.slave   bus,
  output logic [CW-1:0]      conflict_cnt
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] valid_eff;
  logic [NREQ-1:0] a_onehot, b_onehot, same_mask;
  logic            a_found, b_found, conflict;
  logic [IW-1:0]   a_idx, b_idx, b_start;
  logic [AW-1:0]   a_addr;

  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_1_q, we_1_d, we_2_q, we_2_d;
  logic [AW-1:0]   addr_1_q, addr_1_d, addr_2_q, addr_2_d;
  logic [DW-1:0]   data_1_q, data_1_d, data_2_q, data_2_d;

  // Masking valid with hold suppresses every pick, which freezes rr and the counter for free.
  assign valid_eff = bus.req_valid & {NREQ{~hold}};

  wb_port_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .valid (valid_eff),
    .start (rr_q),
    .mask  ('0),
    .found (a_found),
    .idx   (a_idx)
  );

  assign a_addr  = bus.req_addr[a_idx];
  assign b_start = IW'(wrap_inc(int'(a_idx), NREQ));

  always_comb begin
    a_onehot  = '0;
    same_mask = '0;
    if (a_found) a_onehot[a_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      same_mask[i] = (bus.req_addr[i] == a_addr) && (a_addr != '0);
    end
  end

  wb_port_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .valid (valid_eff),
    .start (b_start),
    .mask  (a_onehot | same_mask),
    .found (b_found),
    .idx   (b_idx)
  );

  always_comb begin
    b_onehot = '0;
    if (b_found) b_onehot[b_idx] = 1'b1;
  end

  assign conflict      = a_found && ((valid_eff & same_mask & ~a_onehot) != '0);
  assign bus.req_ready = rst ? ((a_onehot | b_onehot) & valid_eff) : '0;

  always_comb begin
    we_1_d   = a_found;
    addr_1_d = a_found ? bus.req_addr[a_idx] : addr_1_q;
    data_1_d = a_found ? bus.req_data[a_idx] : data_1_q;
    we_2_d   = b_found;
    addr_2_d = b_found ? bus.req_addr[b_idx] : addr_2_q;
    data_2_d = b_found ? bus.req_data[b_idx] : data_2_q;

    rr_d = rr_q;
    if (b_found)      rr_d = IW'(wrap_inc(int'(b_idx), NREQ));
    else if (a_found) rr_d = IW'(wrap_inc(int'(a_idx), NREQ));

    cnt_d = cnt_q;
    if (conflict && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q     <= '0;
      cnt_q    <= '0;
      we_1_q   <= 1'b0;
      addr_1_q <= '0;
      data_1_q <= '0;
      we_2_q   <= 1'b0;
      addr_2_q <= '0;
      data_2_q <= '0;
    end else begin
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      we_1_q   <= we_1_d;
      addr_1_q <= addr_1_d;
      data_1_q <= data_1_d;
      we_2_q   <= we_2_d;
      addr_2_q <= addr_2_d;
      data_2_q <= data_2_d;
    end
  end

  assign bus.we_1        = we_1_q;
  assign bus.writeaddr_1 = addr_1_q;
  assign bus.writedata_1 = data_1_q;
  assign bus.we_2        = we_2_q;
  assign bus.writeaddr_2 = addr_2_q;
  assign bus.writedata_2 = data_2_q;
  assign conflict_cnt    = cnt_q;
endmodule
